// File: rtl/period_meter_pkg.sv
// Shared constants and FSM state encoding for period_meter.
package period_meter_pkg;

    localparam int unsigned DEF_WIDTH   = 16;
    localparam int unsigned DEF_TIMEOUT = 1000;

    typedef logic [1:0] state_t;

    localparam state_t IDLE    = 2'd0;
    localparam state_t MEASURE = 2'd1;
    localparam state_t LOST    = 2'd2;

endpackage

// File: rtl/period_meter_if.sv
// Signal bundle between a period_meter and its user: measured wave in, results out.
interface period_meter_if import period_meter_pkg::*; #(
    parameter int unsigned WIDTH = DEF_WIDTH
);
    logic             sig_in;
    logic             clear;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] high_time;
    logic             meas_valid;
    logic             locked;
    logic             timeout;

    modport master (
        output sig_in, clear,
        input  period, high_time, meas_valid, locked, timeout
    );

    modport slave (
        input  sig_in, clear,
        output period, high_time, meas_valid, locked, timeout
    );
endinterface

// File: rtl/sync_edge_detect.sv
// Conditions sig_in and detects its rising edge; PERIOD_METER_SYNC_EN adds a
// two-flop synchronizer for asynchronous sources.
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic s,
    output logic rise
);
    logic s_q;
    logic s_prev;

`ifdef PERIOD_METER_SYNC_EN
    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            s_q  <= 1'b0;
        end else begin
            meta <= sig_in;
            s_q  <= meta;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) s_q <= 1'b0;
        else     s_q <= sig_in;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) s_prev <= 1'b0;
        else     s_prev <= s_q;
    end

    assign s    = s_q;
    assign rise = s_q & ~s_prev;
endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow square wave in clk cycles, with
// loss-of-signal and lock indication. Front-end option: PERIOD_METER_SYNC_EN.
module period_meter import period_meter_pkg::*; #(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic           clk,
    input  logic           rst,
    period_meter_if.slave  bus
);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] TO_VAL  = WIDTH'(TIMEOUT);

    logic             s;
    logic             rise;
    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] hcnt;
    logic [WIDTH-1:0] period_q;
    logic [WIDTH-1:0] high_q;
    logic             valid_q;
    logic             locked_q;
    logic             timeout_q;

    sync_edge_detect u_front (
        .clk    (clk),
        .rst    (rst),
        .sig_in (bus.sig_in),
        .s      (s),
        .rise   (rise)
    );

    // Priority: clear, then rise, then timeout; a rise on the timeout cycle still measures.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            hcnt      <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (bus.clear) begin
                state     <= IDLE;
                cnt       <= '0;
                hcnt      <= '0;
                locked_q  <= 1'b0;
                timeout_q <= 1'b0;
            end else if (rise) begin
                cnt  <= CNT_ONE;
                hcnt <= CNT_ONE;
                case (state)
                    MEASURE: begin
                        period_q <= cnt;
                        high_q   <= hcnt;
                        valid_q  <= 1'b1;
                        locked_q <= 1'b1;
                    end
                    LOST: begin
                        state     <= MEASURE;
                        timeout_q <= 1'b0;
                    end
                    default: state <= MEASURE;
                endcase
            end else begin
                if (cnt != CNT_MAX)
                    cnt <= cnt + CNT_ONE;
                if (s && hcnt != CNT_MAX)
                    hcnt <= hcnt + CNT_ONE;
                if (cnt == TO_VAL) begin
                    case (state)
                        IDLE: state <= LOST;
                        MEASURE: begin
                            state     <= LOST;
                            timeout_q <= 1'b1;
                            locked_q  <= 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign bus.period     = period_q;
    assign bus.high_time  = high_q;
    assign bus.meas_valid = valid_q;
    assign bus.locked     = locked_q;
    assign bus.timeout    = timeout_q;
endmodule

// File: tb/tb_period_meter.sv
// Directed self-checking bench for period_meter (TIMEOUT=50); latency follows PERIOD_METER_SYNC_EN.
module tb_period_meter;
    localparam int W = 16;
    localparam int T = 50;
`ifdef PERIOD_METER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    period_meter_if #(.WIDTH(W)) bus ();

    period_meter #(.WIDTH(W), .TIMEOUT(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        bus.sig_in = 1'b0;
        bus.clear  = 1'b0;
        repeat (4) tick();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        bus.sig_in = 1'b0;
        bus.clear  = 1'b0;
        repeat (3) tick();
        total_cnt++; if (bus.period !== 16'd0) $display("FAIL reset_period got %0d exp 0", bus.period); else pass_cnt++;
        total_cnt++; if (bus.high_time !== 16'd0) $display("FAIL reset_high got %0d exp 0", bus.high_time); else pass_cnt++;
        total_cnt++; if (bus.meas_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", bus.meas_valid); else pass_cnt++;
        total_cnt++; if (bus.locked !== 1'b0) $display("FAIL reset_locked got %b exp 0", bus.locked); else pass_cnt++;
        total_cnt++; if (bus.timeout !== 1'b0) $display("FAIL reset_timeout got %b exp 0", bus.timeout); else pass_cnt++;
        #3 rst = 1'b0;
        tick();
    endtask

    task automatic test_duty50();
        logic exp_v;
        do_clear();
        for (int c = 0; c < 45; c++) begin
            bus.sig_in = ((c % 10) < 5);
            tick();
            exp_v = (c >= 10 + LAT) && ((c - LAT) % 10 == 0);
            total_cnt++; if (bus.meas_valid !== exp_v) $display("FAIL duty50_valid c=%0d got %b exp %b", c, bus.meas_valid, exp_v); else pass_cnt++;
            total_cnt++; if (bus.locked !== (c >= 10 + LAT)) $display("FAIL duty50_locked c=%0d got %b exp %b", c, bus.locked, (c >= 10 + LAT)); else pass_cnt++;
            if (exp_v) begin
                total_cnt++;
                if (bus.period !== 16'd10 || bus.high_time !== 16'd5)
                    $display("FAIL duty50_meas c=%0d got %0d/%0d exp 10/5", c, bus.period, bus.high_time);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_asym();
        logic exp_v;
        do_clear();
        for (int c = 0; c < 28 + LAT; c++) begin
            bus.sig_in = ((c % 7) < 2);
            tick();
            exp_v = (c >= 7 + LAT) && ((c - LAT) % 7 == 0);
            total_cnt++; if (bus.meas_valid !== exp_v) $display("FAIL asym_valid c=%0d got %b exp %b", c, bus.meas_valid, exp_v); else pass_cnt++;
            if (exp_v) begin
                total_cnt++;
                if (bus.period !== 16'd7 || bus.high_time !== 16'd2)
                    $display("FAIL asym_meas c=%0d got %0d/%0d exp 7/2", c, bus.period, bus.high_time);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_loss();
        logic exp_v, exp_to, exp_lk;
        do_clear();
        for (int c = 0; c < 22 + LAT + T; c++) begin
            bus.sig_in = (c < 25) && ((c % 10) < 5);
            tick();
            exp_v  = (c == 10 + LAT) || (c == 20 + LAT);
            exp_to = (c >= 20 + LAT + T);
            exp_lk = (c >= 10 + LAT) && (c < 20 + LAT + T);
            total_cnt++; if (bus.meas_valid !== exp_v) $display("FAIL loss_valid c=%0d got %b exp %b", c, bus.meas_valid, exp_v); else pass_cnt++;
            total_cnt++; if (bus.timeout !== exp_to) $display("FAIL loss_timeout c=%0d got %b exp %b", c, bus.timeout, exp_to); else pass_cnt++;
            total_cnt++; if (bus.locked !== exp_lk) $display("FAIL loss_locked c=%0d got %b exp %b", c, bus.locked, exp_lk); else pass_cnt++;
        end
        for (int c = 0; c < 21 + LAT; c++) begin
            bus.sig_in = ((c % 10) < 5);
            tick();
            exp_v  = (c == 10 + LAT) || (c == 20 + LAT);
            exp_to = (c < LAT);
            exp_lk = (c >= 10 + LAT);
            total_cnt++; if (bus.meas_valid !== exp_v) $display("FAIL relock_valid c=%0d got %b exp %b", c, bus.meas_valid, exp_v); else pass_cnt++;
            total_cnt++; if (bus.timeout !== exp_to) $display("FAIL relock_timeout c=%0d got %b exp %b", c, bus.timeout, exp_to); else pass_cnt++;
            total_cnt++; if (bus.locked !== exp_lk) $display("FAIL relock_locked c=%0d got %b exp %b", c, bus.locked, exp_lk); else pass_cnt++;
            if (exp_v) begin
                total_cnt++;
                if (bus.period !== 16'd10) $display("FAIL relock_period c=%0d got %0d exp 10", c, bus.period);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_boundary();
        logic exp_v;
        do_clear();
        for (int c = 0; c < 52 + LAT; c++) begin
            bus.sig_in = ((c % 50) < 25);
            tick();
            exp_v = (c == 50 + LAT);
            total_cnt++; if (bus.meas_valid !== exp_v) $display("FAIL bound_valid c=%0d got %b exp %b", c, bus.meas_valid, exp_v); else pass_cnt++;
            total_cnt++; if (bus.timeout !== 1'b0) $display("FAIL bound_timeout c=%0d got %b exp 0", c, bus.timeout); else pass_cnt++;
            if (exp_v) begin
                total_cnt++;
                if (bus.period !== 16'd50 || bus.high_time !== 16'd25)
                    $display("FAIL bound_meas c=%0d got %0d/%0d exp 50/25", c, bus.period, bus.high_time);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_clear_rise();
        logic exp_v, exp_lk;
        logic [W-1:0] exp_p;
        do_clear();
        for (int c = 0; c < 30; c++) begin
            bus.sig_in = (c < 25) && ((c % 10) < 5);
            tick();
        end
        total_cnt++; if (bus.period !== 16'd10) $display("FAIL clr_setup_period got %0d exp 10", bus.period); else pass_cnt++;
        for (int c = 0; c < 15 + LAT; c++) begin
            bus.sig_in = ((c % 7) < 2);
            bus.clear  = (c == LAT);
            tick();
            bus.clear = 1'b0;
            exp_v  = (c == 14 + LAT);
            exp_lk = (c < LAT) || (c >= 14 + LAT);
            exp_p  = (c >= 14 + LAT) ? 16'd7 : 16'd10;
            total_cnt++; if (bus.meas_valid !== exp_v) $display("FAIL clr_valid c=%0d got %b exp %b", c, bus.meas_valid, exp_v); else pass_cnt++;
            total_cnt++; if (bus.locked !== exp_lk) $display("FAIL clr_locked c=%0d got %b exp %b", c, bus.locked, exp_lk); else pass_cnt++;
            total_cnt++; if (bus.period !== exp_p) $display("FAIL clr_period c=%0d got %0d exp %0d", c, bus.period, exp_p); else pass_cnt++;
            if (exp_v) begin
                total_cnt++;
                if (bus.high_time !== 16'd2) $display("FAIL clr_high c=%0d got %0d exp 2", c, bus.high_time);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_async_reset();
        logic exp_v;
        do_clear();
        for (int c = 0; c < 26; c++) begin
            bus.sig_in = ((c % 10) < 5);
            tick();
        end
        total_cnt++; if (bus.locked !== 1'b1) $display("FAIL arst_pre_locked got %b exp 1", bus.locked); else pass_cnt++;
        #3 rst = 1'b1;
        #1;
        total_cnt++; if (bus.period !== 16'd0) $display("FAIL arst_period got %0d exp 0", bus.period); else pass_cnt++;
        total_cnt++; if (bus.high_time !== 16'd0) $display("FAIL arst_high got %0d exp 0", bus.high_time); else pass_cnt++;
        total_cnt++; if (bus.locked !== 1'b0) $display("FAIL arst_locked got %b exp 0", bus.locked); else pass_cnt++;
        total_cnt++; if (bus.meas_valid !== 1'b0 || bus.timeout !== 1'b0) $display("FAIL arst_flags got %b%b exp 00", bus.meas_valid, bus.timeout); else pass_cnt++;
        bus.sig_in = 1'b0;
        tick();
        tick();
        #3 rst = 1'b0;
        for (int c = 0; c < 12 + LAT; c++) begin
            bus.sig_in = ((c % 10) < 5);
            tick();
            exp_v = (c == 10 + LAT);
            total_cnt++; if (bus.meas_valid !== exp_v) $display("FAIL arst_valid c=%0d got %b exp %b", c, bus.meas_valid, exp_v); else pass_cnt++;
            total_cnt++; if (bus.locked !== (c >= 10 + LAT)) $display("FAIL arst_relock c=%0d got %b exp %b", c, bus.locked, (c >= 10 + LAT)); else pass_cnt++;
            if (exp_v) begin
                total_cnt++;
                if (bus.period !== 16'd10 || bus.high_time !== 16'd5)
                    $display("FAIL arst_meas c=%0d got %0d/%0d exp 10/5", c, bus.period, bus.high_time);
                else pass_cnt++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0d checks", total_cnt);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_duty50();
        test_asym();
        test_loss();
        test_boundary();
        test_clear_rise();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/period_meter.md
# period_meter

Measures an asynchronous slow square wave (typically a divided clock produced elsewhere in the design) in units of the fast system clock `clk`. It reports the period and high time of each completed cycle, flags loss of signal, and indicates lock. It is the receiving end of the clock-divider path, used to check and monitor divided clocks on-chip.

## Interface
Parameters:
- `WIDTH`, 16: width of the internal counters and of the `period` and `high_time` outputs.
- `TIMEOUT`, 1000: cycles without a rising edge before loss is declared. Legal range 2 ≤ `TIMEOUT` < 2**`WIDTH`.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `sig_in`  in  1  measured square wave; asynchronous to `clk` when `PERIOD_METER_SYNC_EN` is defined.
- `clear`  in  1  synchronous restart of measurement.
- `period`  out  `WIDTH`  clk cycles between the last two rising edges of `sig_in`.
- `high_time`  out  `WIDTH`  clk cycles `sig_in` was high within that period.
- `meas_valid`  out  1  one-cycle pulse when `period` and `high_time` update.
- `locked`  out  1  high once a valid measurement exists and no timeout has occurred since.
- `timeout`  out  1  sticky loss-of-signal flag.

## Operation
- Front end: `s` is the conditioned `sig_in`. `rise = s & ~s_prev`.
- Counters:
  - `cnt` counts clk cycles since the last rise. It is loaded to 1 on a rise, otherwise incremented, and saturates at 2**`WIDTH`-1.
  - `hcnt` is loaded to 1 on a rise, otherwise incremented when `s`=1.
  - For a wave of period P and high time H, this gives `period`=P and `high_time`=H.
- FSM states: IDLE, MEASURE, LOST.
  - IDLE, after reset or `clear`: on `rise`, go to MEASURE and load the counters; no `meas_valid`. If `cnt`==`TIMEOUT`, go to LOST.
  - MEASURE: on `rise`, latch `period`←`cnt` and `high_time`←`hcnt`, pulse `meas_valid`, set `locked`, and reload the counters. If there is no rise and `cnt`==`TIMEOUT`, go to LOST, set `timeout`=1 and clear `locked`.
  - LOST: on `rise`, go to MEASURE, clear `timeout` and reload the counters. The first period after a loss is discarded (no `meas_valid`).
- `clear`: state→IDLE, counters→0, and `timeout`, `locked`, `meas_valid`→0. `period` and `high_time` keep their values.
- Priority: `rst` > `clear` > `rise` > timeout.
  - `clear` together with `rise`: the rise is ignored.
  - `rise` together with `cnt`==`TIMEOUT`: a valid measurement with `period`=`TIMEOUT`; no timeout.
- Reset: every output is 0, state is IDLE, counters are 0 and the front-end flops are 0.

## Timing
- `period`, `high_time`, `meas_valid`, `locked` and `timeout` are all registered.
- Latency from `sig_in` rising (setup met before clk edge 0) to `meas_valid` high:
  - With `PERIOD_METER_SYNC_EN`: `meas_valid` is high after edge 2.
  - Without it: `meas_valid` is high after edge 1.
- `meas_valid` lasts exactly one cycle. Back-to-back pulses are impossible, because P ≥ 2 is required for detection.
- `timeout` rises on the edge after the cycle in which `cnt`==`TIMEOUT`, i.e. `TIMEOUT` cycles after the last rise.
- `rst` clears all flops immediately, without waiting for a clock edge.

## Configuration
- `PERIOD_METER_SYNC_EN` defined: `sig_in` passes through a two-flop synchronizer before the edge-detect flop. Use this for asynchronous sources.
- Not defined: `sig_in` is registered once only and must be synchronous to `clk`. Latency is one cycle shorter.
- Measured values are identical in both builds.

## Structure
- Package `period_meter_pkg` holds the FSM state type (IDLE, MEASURE, LOST, 2-bit encoding) and the default `WIDTH`/`TIMEOUT` constants.
- Sub-module `sync_edge_detect` contains the synchronizer, the `s_prev` flop and the `rise` output. `PERIOD_METER_SYNC_EN` is confined to it.
- Top level contains the FSM, counters and output registers.

## Test plan
- 50% duty: `sig_in` period 10, high 5 (e.g. driven by a divide-by-5 toggle) → from the second rise on, `meas_valid` every 10 cycles with `period`=10, `high_time`=5, `locked`=1.
- Asymmetric duty: period 7, high 2 → `period`=7, `high_time`=2. Repeat with the macro off and check latency is one cycle shorter.
- Loss of signal: `TIMEOUT`=50, hold `sig_in` low after a rise → `timeout`=1 and `locked`=0 exactly 50 cycles after that rise. Restart the wave → no valid on the first rise, valid on the second, `timeout` cleared on the first.
- Boundary: period exactly equal to `TIMEOUT` → valid measurement with `period`=`TIMEOUT` and `timeout` stays 0.
- Assert `clear` in the same cycle as `rise` → no `meas_valid`; the next valid occurs only after two further rises; `period` keeps its old value meanwhile.
- Assert `rst` mid-period, asynchronous to `clk` → all outputs 0 immediately; measurement resumes from IDLE after release.
